// File: rtl/coax_tx_sequencer.sv
// Frame sequencer in front of coax_tx: queues host words in a FIFO and streams them
// as one back-to-back frame per start request, with inter-frame gap and stall detection.
//
// state | meaning
// IDLE  | no frame in progress; waiting for start with words queued
// LOAD  | offering the FIFO head to coax_tx, popping on tx_ready
// DRAIN | last word handed off; waiting for coax_tx to release the line
// GAP   | counting quiet clocks before the next frame may begin
module coax_tx_sequencer #(
    parameter int DEPTH   = 16,
    parameter int MIN_GAP = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [9:0] wr_data,
    input  logic       start,
    input  logic       clear,
    output logic       tx_load,
    output logic [9:0] tx_data,
    input  logic       tx_ready,
    input  logic       tx_active,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
    logic [CW-1:0] count;
    logic [TW-1:0] tmr;
    logic [GW-1:0] gap_cnt;
    logic          push, pop, timeout;
    logic [9:0]    head_nxt;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle frees the slot, so a write to a full FIFO is legal then.
    assign pop     = (state == LOAD) && tx_ready;
    assign push    = wr_en && (!full || pop);
    assign timeout = (state == LOAD) && !tx_ready && (tmr == '0);

    always_ff @(posedge clk) begin
        if (push && !timeout) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (timeout) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Stall timer: reloaded on LOAD entry and on every accepted word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr <= '0;
        end else if ((state_nxt == LOAD) && ((state != LOAD) || tx_ready)) begin
            tmr <= TW'(TIMEOUT - 1);
        end else if ((state == LOAD) && (tmr != '0)) begin
            tmr <= tmr - TW'(1);
        end
    end

    // Gap timer restarts whenever the line goes busy again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if ((state_nxt == GAP) && ((state != GAP) || tx_active)) begin
            gap_cnt <= GW'(MIN_GAP - 1);
        end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            fault    <= 1'b0;
        end else begin
            if (clear) begin
                overflow <= 1'b0;
            end else if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
            if (clear) begin
                fault <= 1'b0;
            end else if (timeout) begin
                fault <= 1'b1;
            end
        end
    end

    // Next head word; a push into a FIFO that the pop just emptied bypasses memory.
    always_comb begin
        rd_ptr_nxt = pop ? (rd_ptr + AW'(1)) : rd_ptr;
        if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = wr_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data <= '0;
        end else if (state_nxt == LOAD) begin
            tx_data <= head_nxt;
        end else begin
            tx_data <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (timeout) begin
                    state_nxt = DRAIN;
                end else if (pop && !push && (count == CW'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!tx_active) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (!tx_active && (gap_cnt == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_load = 1'b0;
        busy    = 1'b1;
        case (state)
            IDLE:    busy    = 1'b0;
            LOAD:    tx_load = 1'b1;
            default: tx_load = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_coax_tx_sequencer.sv
// Bench for coax_tx_sequencer: directed scenarios with random data and handshakes,
// every cycle compared against a queue-based model of the frame behaviour.
module tb_coax_tx_sequencer;

    localparam int DEPTH   = 8;
    localparam int MIN_GAP = 12;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       reset, wr_en, start, clear, tx_ready, tx_active;
    logic [9:0] wr_data;
    logic       tx_load, busy, full, empty, overflow, fault;
    logic [9:0] tx_data;

    coax_tx_sequencer #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start),
        .clear(clear), .tx_load(tx_load), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_active(tx_active), .busy(busy), .full(full), .empty(empty),
        .overflow(overflow), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_SEND, M_WAIT, M_GAP} mph_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] q[$];
    mph_t       ph = M_IDLE;
    int         stall = 0, quiet = 0, cyc = 0, fall_cyc = 0;
    bit         m_ovf = 0, m_fault = 0, prev_act = 0, have_fall = 0, prev_load = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit         exp_load;
        logic [9:0] exp_data;
        exp_load = (ph == M_SEND);
        exp_data = exp_load ? q[0] : 10'h000;
        check("tx_load",  32'(tx_load),  32'(exp_load));
        check("tx_data",  32'(tx_data),  32'(exp_data));
        check("busy",     32'(busy),     32'(ph != M_IDLE));
        check("full",     32'(full),     32'(q.size() == DEPTH));
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("fault",    32'(fault),    32'(m_fault));
        if (tx_load === 1'b1 && !prev_load && have_fall)
            check("min_gap", 32'((cyc - fall_cyc) >= MIN_GAP), 32'(1));
        prev_load = (tx_load === 1'b1);
    endtask

    // Apply one clock of inputs (called at a falling edge) and advance the model.
    task automatic tick(input bit wr, input logic [9:0] wd, input bit st, input bit clr,
                        input bit rdy, input bit act);
        bit pop, push, tmo, was_full;
        wr_en = wr; wr_data = wd; start = st; clear = clr; tx_ready = rdy; tx_active = act;
        pop      = (ph == M_SEND) && rdy;
        was_full = (q.size() == DEPTH);
        push     = wr && (!was_full || pop);
        tmo      = 0;
        if (ph == M_SEND) begin
            if (rdy) stall = 0;
            else begin
                stall++;
                tmo = (stall == TIMEOUT);
            end
        end
        if (clr) m_ovf = 0;
        else if (wr && was_full && !pop) m_ovf = 1;
        if (clr) m_fault = 0;
        else if (tmo) m_fault = 1;
        case (ph)
            M_IDLE: if (st && q.size() > 0) begin ph = M_SEND; stall = 0; end
            M_SEND: if (tmo) begin q.delete(); ph = M_WAIT; end
            M_WAIT: if (!act) begin ph = M_GAP; quiet = 0; end
            M_GAP: begin
                if (act) quiet = 0;
                else quiet++;
                if (quiet == MIN_GAP) ph = M_IDLE;
            end
            default: ph = M_IDLE;
        endcase
        if (!tmo) begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(wd);
            if (pop && q.size() == 0) ph = M_WAIT;
        end
        if (!act && prev_act) begin
            fall_cyc  = cyc;
            have_fall = 1;
        end
        prev_act = act;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic model_reset();
        q.delete();
        ph = M_IDLE; stall = 0; quiet = 0; m_ovf = 0; m_fault = 0;
        prev_act = 0; have_fall = 0; prev_load = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_load"},  32'(tx_load),  32'(0));
        check({tag, "_tx_data"},  32'(tx_data),  32'(0));
        check({tag, "_busy"},     32'(busy),     32'(0));
        check({tag, "_full"},     32'(full),     32'(0));
        check({tag, "_empty"},    32'(empty),    32'(1));
        check({tag, "_overflow"}, 32'(overflow), 32'(0));
        check({tag, "_fault"},    32'(fault),    32'(0));
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) tick(1, 10'($urandom), 0, 0, 0, 0);
    endtask

    // Start a frame and run random handshakes until the model is idle again.
    task automatic run_frame(input int extra_pct);
        int guard = 0;
        int hold  = $urandom_range(0, 5);
        bit rdy, wr, st, act;
        tick(0, 10'h000, 1, 0, 0, 0);
        while (ph != M_IDLE && guard < 3000) begin
            rdy = ($urandom_range(0, 3) != 0);
            wr  = (ph == M_SEND) && ($urandom_range(0, 99) < extra_pct);
            st  = ($urandom_range(0, 3) == 0);
            if (ph == M_SEND) act = 1;
            else if (ph == M_WAIT && hold > 0) begin act = 1; hold--; end
            else if (ph == M_GAP) act = ($urandom_range(0, 40) == 0);
            else act = 0;
            tick(wr, 10'($urandom), st, 0, rdy, act);
            guard++;
        end
        check("frame_done", 32'(guard < 3000), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; wr_en = 0; wr_data = '0; start = 0; clear = 0; tx_ready = 0; tx_active = 0;
        @(negedge clk);
        model_reset();
        check_reset_values("reset");
        @(negedge clk);
        reset = 0;
        tick(0, 10'h000, 0, 0, 0, 0);

        // Three fixed words sent in order, then drain and gap.
        tick(1, 10'h005, 0, 0, 0, 0);
        tick(1, 10'h1A3, 0, 0, 0, 0);
        tick(1, 10'h3FF, 0, 0, 0, 0);
        tick(0, 10'h000, 1, 0, 0, 0);
        check("t1_latency", 32'(tx_load), 32'(1));
        check("t1_word0", 32'(tx_data), 32'(10'h005));
        tick(0, 10'h000, 0, 0, 1, 1);
        check("t1_word1", 32'(tx_data), 32'(10'h1A3));
        tick(0, 10'h000, 0, 0, 0, 1);
        tick(0, 10'h000, 0, 0, 1, 1);
        check("t1_word2", 32'(tx_data), 32'(10'h3FF));
        tick(0, 10'h000, 0, 0, 1, 1);
        check("t1_load_low", 32'(tx_load), 32'(0));
        tick(0, 10'h000, 1, 0, 0, 1);
        tick(0, 10'h000, 1, 0, 0, 1);
        for (int i = 0; i < MIN_GAP; i++) tick(0, 10'h000, (i == 3), 0, 0, 0);
        check("t1_busy_gap", 32'(busy), 32'(1));
        tick(0, 10'h000, 0, 0, 0, 0);
        check("t1_idle", 32'(busy), 32'(0));

        // Overflow, and clear beating a same-cycle overflow event.
        write_words(DEPTH + 1);
        check("t2_full", 32'(full), 32'(1));
        check("t2_overflow", 32'(overflow), 32'(1));
        tick(0, 10'h000, 0, 1, 0, 0);
        check("t2_clear", 32'(overflow), 32'(0));
        tick(1, 10'($urandom), 0, 1, 0, 0);
        check("t2_clear_wins", 32'(overflow), 32'(0));
        tick(1, 10'($urandom), 0, 0, 0, 0);
        check("t2_reset_again", 32'(overflow), 32'(1));
        tick(0, 10'h000, 0, 1, 0, 0);
        run_frame(0);

        // Random frames with words appended mid-frame and ignored starts.
        for (int f = 0; f < 6; f++) begin
            write_words($urandom_range(1, DEPTH));
            run_frame(30);
        end

        // Stalled transmitter.
        write_words(2);
        tick(0, 10'h000, 1, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) tick(0, 10'h000, 0, 0, 0, 1);
        check("t5_fault", 32'(fault), 32'(1));
        check("t5_empty", 32'(empty), 32'(1));
        check("t5_drain", 32'(busy), 32'(1));
        tick(0, 10'h000, 0, 1, 0, 0);
        check("t5_clear", 32'(fault), 32'(0));
        for (int i = 0; i < MIN_GAP + 2; i++) tick(0, 10'h000, 0, 0, 0, 0);

        // Reset in the middle of a frame.
        write_words(3);
        tick(0, 10'h000, 1, 0, 0, 1);
        tick(0, 10'h000, 0, 0, 1, 1);
        #2 reset = 1;
        #1;
        model_reset();
        check_reset_values("t6_async");
        @(negedge clk);
        reset = 0;
        tick(0, 10'h000, 1, 0, 0, 0);
        check("t6_start_empty", 32'(busy), 32'(0));
        tick(0, 10'h000, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
